// File: rtl/rs_ls_queue_pkg.sv
// rs_ls_queue_pkg: shared widths, UNLOCKED tag constant and lowest-index broadcast priority helper.
package rs_ls_queue_pkg;
  localparam int TAG_BITS = 4;
  localparam int DATA_BITS = 32;
  localparam int OP_BITS = 6;
  localparam int RADDR_BITS = 5;
  localparam int UNLOCKED = 0;
  localparam int MAX_BCAST = 16;
  localparam int BC_IDX_W = $clog2(MAX_BCAST);
  typedef logic [TAG_BITS-1:0] tag_t;
  typedef logic [DATA_BITS-1:0] word_t;
  typedef logic [OP_BITS-1:0] op_t;
  typedef logic [RADDR_BITS-1:0] raddr_t;
  function automatic logic [BC_IDX_W-1:0] first_hit(input logic [MAX_BCAST-1:0] hits);
    first_hit = '0;
    for (int i = MAX_BCAST - 1; i >= 0; i--)
      if (hits[i]) first_hit = BC_IDX_W'(i);
  endfunction
endpackage

// File: rtl/rs_ls_entry_cap.sv
// rs_ls_entry_cap: one operand's tag/data capture against all broadcast channels, lowest channel wins.
module rs_ls_entry_cap
  import rs_ls_queue_pkg::*;
#(
  parameter int NUM_BCAST = 3,
  parameter int TAG_W = TAG_BITS,
  parameter int DATA_W = DATA_BITS
) (
  input  logic                        i_en,
  input  logic [TAG_W-1:0]            i_tag,
  input  logic [DATA_W-1:0]           i_data,
  input  logic [NUM_BCAST-1:0]        i_bc_valid,
  input  logic [NUM_BCAST*TAG_W-1:0]  i_bc_tag,
  input  logic [NUM_BCAST*DATA_W-1:0] i_bc_data,
  output logic [TAG_W-1:0]            o_tag,
  output logic [DATA_W-1:0]           o_data
);
  logic [MAX_BCAST-1:0] w_hits;
  logic [BC_IDX_W-1:0] w_sel;
  logic w_hit;
  always_comb begin
    w_hits = '0;
    for (int c = 0; c < NUM_BCAST; c++)
      w_hits[c] = i_en && i_bc_valid[c] && i_tag != TAG_W'(UNLOCKED) && i_bc_tag[c*TAG_W +: TAG_W] == i_tag;
  end
  assign w_sel = first_hit(w_hits);
  assign w_hit = |w_hits;
  assign o_tag = w_hit ? TAG_W'(UNLOCKED) : i_tag;
  assign o_data = w_hit ? i_bc_data[int'(w_sel)*DATA_W +: DATA_W] : i_data;
endmodule

// File: rtl/rs_ls_queue.sv
// rs_ls_queue: in-order load/store reservation station with broadcast operand capture.
// Define RS_LS_QUEUE_BYPASS_EN to let the head issue in the same cycle its last operand is broadcast.
module rs_ls_queue
  import rs_ls_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int NUM_BCAST = 3,
  parameter int TAG_W = TAG_BITS,
  parameter int DATA_W = DATA_BITS,
  parameter int OP_W = OP_BITS,
  parameter int RADDR_W = RADDR_BITS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rdy,
  input  logic                        flush,
  input  logic                        alloc_en,
  input  logic [OP_W-1:0]             alloc_op,
  input  logic [TAG_W-1:0]            alloc_tagx,
  input  logic [TAG_W-1:0]            alloc_tagy,
  input  logic [TAG_W-1:0]            alloc_tagw,
  input  logic [DATA_W-1:0]           alloc_datax,
  input  logic [DATA_W-1:0]           alloc_datay,
  input  logic [RADDR_W-1:0]          alloc_target,
  output logic                        full,
  output logic [$clog2(DEPTH):0]      count,
  input  logic [NUM_BCAST-1:0]        bc_valid,
  input  logic [NUM_BCAST*TAG_W-1:0]  bc_tag,
  input  logic [NUM_BCAST*DATA_W-1:0] bc_data,
  output logic                        iss_valid,
  input  logic                        iss_ready,
  output logic [OP_W-1:0]             iss_op,
  output logic [DATA_W-1:0]           iss_datax,
  output logic [DATA_W-1:0]           iss_datay,
  output logic [TAG_W-1:0]            iss_tagw,
  output logic [RADDR_W-1:0]          iss_target
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [DEPTH-1:0] r_valid;
  logic [OP_W-1:0] r_op [DEPTH];
  logic [TAG_W-1:0] r_tagx [DEPTH];
  logic [TAG_W-1:0] r_tagy [DEPTH];
  logic [TAG_W-1:0] r_tagw [DEPTH];
  logic [DATA_W-1:0] r_datax [DEPTH];
  logic [DATA_W-1:0] r_datay [DEPTH];
  logic [RADDR_W-1:0] r_target [DEPTH];
  logic [PW-1:0] r_head, r_tail;
  logic [CW-1:0] r_count;
  logic r_full;
  logic [TAG_W-1:0] w_tagx [DEPTH];
  logic [TAG_W-1:0] w_tagy [DEPTH];
  logic [DATA_W-1:0] w_datax [DEPTH];
  logic [DATA_W-1:0] w_datay [DEPTH];
  logic [TAG_W-1:0] w_atagx, w_atagy;
  logic [DATA_W-1:0] w_adatax, w_adatay;
  logic w_push, w_pop;
  logic [CW-1:0] w_count_nxt;
  for (genvar e = 0; e < DEPTH; e++) begin : g_ent
    rs_ls_entry_cap #(.NUM_BCAST(NUM_BCAST), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_x (
      .i_en(r_valid[e]), .i_tag(r_tagx[e]), .i_data(r_datax[e]),
      .i_bc_valid(bc_valid), .i_bc_tag(bc_tag), .i_bc_data(bc_data),
      .o_tag(w_tagx[e]), .o_data(w_datax[e]));
    rs_ls_entry_cap #(.NUM_BCAST(NUM_BCAST), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_y (
      .i_en(r_valid[e]), .i_tag(r_tagy[e]), .i_data(r_datay[e]),
      .i_bc_valid(bc_valid), .i_bc_tag(bc_tag), .i_bc_data(bc_data),
      .o_tag(w_tagy[e]), .o_data(w_datay[e]));
  end
  // Incoming operands snoop the same-cycle broadcasts so a result is never missed at allocation.
  rs_ls_entry_cap #(.NUM_BCAST(NUM_BCAST), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_ax (
    .i_en(1'b1), .i_tag(alloc_tagx), .i_data(alloc_datax),
    .i_bc_valid(bc_valid), .i_bc_tag(bc_tag), .i_bc_data(bc_data),
    .o_tag(w_atagx), .o_data(w_adatax));
  rs_ls_entry_cap #(.NUM_BCAST(NUM_BCAST), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_ay (
    .i_en(1'b1), .i_tag(alloc_tagy), .i_data(alloc_datay),
    .i_bc_valid(bc_valid), .i_bc_tag(bc_tag), .i_bc_data(bc_data),
    .o_tag(w_atagy), .o_data(w_adatay));
`ifdef RS_LS_QUEUE_BYPASS_EN
  assign iss_valid = rdy && r_valid[r_head] && w_tagx[r_head] == TAG_W'(UNLOCKED) && w_tagy[r_head] == TAG_W'(UNLOCKED);
  assign iss_datax = w_datax[r_head];
  assign iss_datay = w_datay[r_head];
`else
  assign iss_valid = rdy && r_valid[r_head] && r_tagx[r_head] == TAG_W'(UNLOCKED) && r_tagy[r_head] == TAG_W'(UNLOCKED);
  assign iss_datax = r_datax[r_head];
  assign iss_datay = r_datay[r_head];
`endif
  assign iss_op = r_op[r_head];
  assign iss_tagw = r_tagw[r_head];
  assign iss_target = r_target[r_head];
  assign full = r_full;
  assign count = r_count;
  assign w_pop = iss_valid && iss_ready && !flush;
  assign w_push = rdy && alloc_en && !r_full && !flush;
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
      r_head <= '0;
      r_tail <= '0;
      r_count <= '0;
      r_full <= 1'b0;
      for (int e = 0; e < DEPTH; e++) begin
        r_op[e] <= '0;
        r_tagx[e] <= TAG_W'(UNLOCKED);
        r_tagy[e] <= TAG_W'(UNLOCKED);
        r_tagw[e] <= TAG_W'(UNLOCKED);
        r_datax[e] <= '0;
        r_datay[e] <= '0;
        r_target[e] <= '0;
      end
    end else if (rdy) begin
      if (flush) begin
        r_valid <= '0;
        r_head <= '0;
        r_tail <= '0;
        r_count <= '0;
        r_full <= 1'b0;
      end else begin
        for (int e = 0; e < DEPTH; e++) begin
          r_tagx[e] <= w_tagx[e];
          r_tagy[e] <= w_tagy[e];
          r_datax[e] <= w_datax[e];
          r_datay[e] <= w_datay[e];
        end
        if (w_pop) begin
          r_valid[r_head] <= 1'b0;
          r_head <= r_head + PW'(1);
        end
        if (w_push) begin
          r_valid[r_tail] <= 1'b1;
          r_op[r_tail] <= alloc_op;
          r_tagx[r_tail] <= w_atagx;
          r_tagy[r_tail] <= w_atagy;
          r_tagw[r_tail] <= alloc_tagw;
          r_datax[r_tail] <= w_adatax;
          r_datay[r_tail] <= w_adatay;
          r_target[r_tail] <= alloc_target;
          r_tail <= r_tail + PW'(1);
        end
        r_count <= w_count_nxt;
        r_full <= w_count_nxt == CW'(DEPTH);
      end
    end
  end
endmodule

// File: tb/tb_rs_ls_queue.sv
// tb_rs_ls_queue: directed plan scenarios plus random traffic against a queue-based reference model.
module tb_rs_ls_queue;
  localparam int DEPTH = 4;
  localparam int NB = 3;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rdy, flush, alloc_en, full, iss_valid, iss_ready;
  logic [5:0] alloc_op, iss_op;
  logic [3:0] alloc_tagx, alloc_tagy, alloc_tagw, iss_tagw;
  logic [31:0] alloc_datax, alloc_datay, iss_datax, iss_datay;
  logic [4:0] alloc_target, iss_target;
  logic [2:0] count;
  logic [NB-1:0] bc_valid;
  logic [NB*4-1:0] bc_tag;
  logic [NB*32-1:0] bc_data;
  typedef struct packed {
    logic [5:0] op;
    logic [3:0] tx, ty, tw;
    logic [31:0] dx, dy;
    logic [4:0] tgt;
  } ent_t;
  ent_t q[$];
  int n_cmp = 0;
  int n_err = 0;
  rs_ls_queue dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .alloc_en(alloc_en),
    .alloc_op(alloc_op), .alloc_tagx(alloc_tagx), .alloc_tagy(alloc_tagy), .alloc_tagw(alloc_tagw),
    .alloc_datax(alloc_datax), .alloc_datay(alloc_datay), .alloc_target(alloc_target),
    .full(full), .count(count), .bc_valid(bc_valid), .bc_tag(bc_tag), .bc_data(bc_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op), .iss_datax(iss_datax),
    .iss_datay(iss_datay), .iss_tagw(iss_tagw), .iss_target(iss_target));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  // First channel (lowest index) carrying a matching tag supplies the value.
  function automatic void snoop(input logic [3:0] t, input logic [31:0] d, output logic [3:0] to, output logic [31:0] dout);
    bit found = 0;
    to = t;
    dout = d;
    if (t != 0)
      for (int c = 0; c < NB; c++)
        if (!found && bc_valid[c] && bc_tag[c*4 +: 4] == t) begin
          found = 1;
          to = 0;
          dout = bc_data[c*32 +: 32];
        end
  endfunction
  task automatic idle();
    rdy = 1; flush = 0; alloc_en = 0; bc_valid = '0; iss_ready = 0;
  endtask
  task automatic set_alloc(input logic [3:0] tx, input logic [3:0] ty, input logic [31:0] dx, input logic [31:0] dy);
    alloc_en = 1;
    alloc_op = 6'($urandom);
    alloc_tagx = tx;
    alloc_tagy = ty;
    alloc_tagw = 4'($urandom);
    alloc_datax = dx;
    alloc_datay = dy;
    alloc_target = 5'($urandom);
  endtask
  task automatic bc(input int c, input logic [3:0] t, input logic [31:0] d);
    bc_valid[c] = 1;
    bc_tag[c*4 +: 4] = t;
    bc_data[c*32 +: 32] = d;
  endtask
  // Called just after a falling edge with inputs set; checks outputs, then advances the model one edge.
  task automatic step();
    ent_t h, e;
    logic ev, fl;
    #1;
    ev = 0;
    if (q.size() > 0) begin
      h = q[0];
`ifdef RS_LS_QUEUE_BYPASS_EN
      snoop(h.tx, h.dx, h.tx, h.dx);
      snoop(h.ty, h.dy, h.ty, h.dy);
`endif
      ev = rdy && h.tx == 0 && h.ty == 0;
    end
    chk("iss_valid", 64'(iss_valid), 64'(ev));
    chk("count", 64'(count), 64'(q.size()));
    chk("full", 64'(full), 64'(q.size() == DEPTH));
    if (ev) begin
      chk("iss_op", 64'(iss_op), 64'(h.op));
      chk("iss_datax", 64'(iss_datax), 64'(h.dx));
      chk("iss_datay", 64'(iss_datay), 64'(h.dy));
      chk("iss_tagw", 64'(iss_tagw), 64'(h.tw));
      chk("iss_target", 64'(iss_target), 64'(h.tgt));
    end
    @(posedge clk);
    if (rdy) begin
      if (flush) q.delete();
      else begin
        fl = q.size() == DEPTH;
        for (int i = 0; i < q.size(); i++) begin
          e = q[i];
          snoop(e.tx, e.dx, e.tx, e.dx);
          snoop(e.ty, e.dy, e.ty, e.dy);
          q[i] = e;
        end
        if (ev && iss_ready) void'(q.pop_front());
        if (alloc_en && !fl) begin
          e.op = alloc_op;
          e.tw = alloc_tagw;
          e.tgt = alloc_target;
          snoop(alloc_tagx, alloc_datax, e.tx, e.dx);
          snoop(alloc_tagy, alloc_datay, e.ty, e.dy);
          q.push_back(e);
        end
      end
    end
    @(negedge clk);
  endtask
  task automatic rand_in();
    rdy = ($urandom % 8) != 0;
    flush = ($urandom % 60) == 0;
    alloc_en = $urandom % 2;
    alloc_op = 6'($urandom);
    alloc_tagx = 4'($urandom % 4);
    alloc_tagy = 4'($urandom % 4);
    alloc_tagw = 4'($urandom);
    alloc_datax = $urandom;
    alloc_datay = $urandom;
    alloc_target = 5'($urandom);
    bc_valid = NB'($urandom);
    for (int c = 0; c < NB; c++) begin
      bc_tag[c*4 +: 4] = 4'($urandom_range(1, 3));
      bc_data[c*32 +: 32] = $urandom;
    end
    iss_ready = $urandom % 2;
  endtask
  task automatic do_reset();
    rst = 0;
    #2;
    q.delete();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_valid", 64'(iss_valid), 64'd0);
    @(negedge clk);
    rst = 1;
  endtask
  initial begin
    idle();
    bc_tag = '0;
    bc_data = '0;
    alloc_op = 0; alloc_tagx = 0; alloc_tagy = 0; alloc_tagw = 0;
    alloc_datax = 0; alloc_datay = 0; alloc_target = 0;
    #2;
    chk("rst0_count", 64'(count), 64'd0);
    chk("rst0_valid", 64'(iss_valid), 64'd0);
    chk("rst0_datax", 64'(iss_datax), 64'd0);
    chk("rst0_op", 64'(iss_op), 64'd0);
    @(negedge clk);
    rst = 1;
    for (int i = 0; i < 4; i++) begin
      set_alloc(0, 0, 32'h10 + i, 32'h20 + i);
      step();
    end
    set_alloc(0, 0, 32'h99, 32'h99);
    step();
    idle();
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_count", 64'(count), 64'd4);
    iss_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_datax", 64'(iss_datax), 64'h10 + 64'(i));
      step();
    end
    chk("drain_count", 64'(count), 64'd0);
    set_alloc(5, 0, 32'h1, 32'h2);
    step();
    set_alloc(0, 0, 32'h77, 32'h78);
    step();
    idle();
    chk("block_valid", 64'(iss_valid), 64'd0);
    step();
    bc(1, 4'd5, 32'hDEAD);
    step();
    idle();
    chk("wake_valid", 64'(iss_valid), 64'd1);
    chk("wake_datax", 64'(iss_datax), 64'hDEAD);
    iss_ready = 1;
    step();
    chk("follow_datax", 64'(iss_datax), 64'h77);
    step();
    idle();
    set_alloc(0, 7, 32'h5, 32'h1234);
    bc(0, 4'd7, 32'hAAAA);
    bc(2, 4'd7, 32'hBBBB);
    step();
    idle();
    chk("prio_valid", 64'(iss_valid), 64'd1);
    chk("prio_datay", 64'(iss_datay), 64'hAAAA);
    iss_ready = 1;
    step();
    idle();
    for (int i = 0; i < 3; i++) begin
      set_alloc(0, 0, 32'h40 + i, 32'h50 + i);
      step();
    end
    idle();
    rdy = 0;
    iss_ready = 1;
    for (int i = 0; i < 3; i++) step();
    rdy = 1;
    iss_ready = 0;
    for (int i = 0; i < 3; i++) step();
    chk("stall_datax", 64'(iss_datax), 64'h40);
    chk("stall_count", 64'(count), 64'd3);
    for (int i = 0; i < 10; i++) begin
      set_alloc(0, 0, 32'h100 + i, 32'h200 + i);
      iss_ready = 1;
      step();
    end
    idle();
    chk("wrap_count", 64'(count), 64'd3);
    chk("wrap_datax", 64'(iss_datax), 64'h107);
    iss_ready = 1;
    step();
    idle();
    set_alloc(0, 0, 32'h33, 32'h34);
    iss_ready = 1;
    flush = 1;
    step();
    idle();
    chk("flush_count", 64'(count), 64'd0);
    for (int i = 0; i < 3; i++) begin
      set_alloc(4'(i), 0, 32'h60 + i, 32'h0);
      step();
    end
    idle();
    rand_in();
    do_reset();
    idle();
    set_alloc(0, 0, 32'h5A, 32'h5B);
    step();
    idle();
    chk("post_rst_datax", 64'(iss_datax), 64'h5A);
    step();
    for (int i = 0; i < 3000; i++) begin
      rand_in();
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/rs_ls_queue.md
Name: rs_ls_queue

Overview:
- Multi-entry, in-order reservation station for the load/store unit; parametrised successor of the single-slot LS station.
- Holds DEPTH pending memory ops, captures source operands from NUM_BCAST result-broadcast channels, and issues the oldest ready entry to the LS executor over a valid/ready handshake.
- Sits between the allocator/dispatch stage and the LS executor.
- Issue is strictly in program order to preserve memory ordering.

Parameters:
- DEPTH, 4, number of entries; power of two, >=2.
- NUM_BCAST, 3, number of broadcast channels (alu0, alu1, ls by default).
- TAG_W, 4, register-tag width; tag value 0 = UNLOCKED (operand present).
- DATA_W, 32, operand width.
- OP_W, 6, decoded instruction-op width.
- RADDR_W, 5, destination register address width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- rdy  in  1  global enable; low freezes all state.
- flush  in  1  synchronous squash of all entries.
- alloc_en  in  1  allocate one entry this cycle.
- alloc_op  in  OP_W  op.
- alloc_tagx, alloc_tagy  in  TAG_W  source tags.
- alloc_tagw  in  TAG_W  destination tag.
- alloc_datax, alloc_datay  in  DATA_W  source data (valid when tag UNLOCKED).
- alloc_target  in  RADDR_W  destination register.
- full  out  1  count==DEPTH (registered).
- count  out  $clog2(DEPTH)+1  occupied entries.
- bc_valid  in  NUM_BCAST  per-channel result valid (active high).
- bc_tag  in  NUM_BCAST*TAG_W  packed tags, channel 0 in LSBs.
- bc_data  in  NUM_BCAST*DATA_W  packed data.
- iss_valid  out  1  head entry ready to issue.
- iss_ready  in  1  LS executor accepts.
- iss_op  out  OP_W  head op.
- iss_datax, iss_datay  out  DATA_W  head operands.
- iss_tagw  out  TAG_W  head destination tag.
- iss_target  out  RADDR_W  head destination register.

Behaviour:
- Storage: circular buffer, head/tail pointers of $clog2(DEPTH) bits, wrap naturally; count tracks occupancy.
- Reset (rst=0, async): head=tail=count=0, all entries invalid, all entry tags UNLOCKED, all data 0. Outputs: full=0, iss_valid=0, iss_* = 0.
- rdy=0: no state change; iss_valid forced 0; broadcasts ignored.
- Allocate: on alloc_en && !full, write entry at tail and advance tail. Each incoming tag is checked against same-cycle broadcasts; on a match the entry stores UNLOCKED plus the broadcast data.
- alloc_en while full: request dropped, no state change; a bench assertion flags it. full is registered, so a same-cycle issue does not make room for an allocation.
- Capture: every valid entry compares tag_x/tag_y against each channel with bc_valid=1. On a match, the tag becomes UNLOCKED and the data is written on the next edge.
- Broadcast matching rules: UNLOCKED never matches. If several channels match, the lowest channel index wins.
- Issue: iss_valid = rdy && head valid && head tag_x and tag_y both UNLOCKED. Younger ready entries never bypass the head.
- Handshake: iss_valid && iss_ready pops the head and advances head. iss_* are stable while iss_valid && !iss_ready.
- Latency:
  - Alloc with both tags UNLOCKED: iss_valid in the next cycle.
  - Last operand broadcast: iss_valid in the next cycle.
- Simultaneous alloc and issue (not full): count unchanged, both take effect.
- Empty: iss_valid=0, count=0.
- flush=1 (with rdy=1): all entries invalid, head=tail=count=0 on the next edge. flush overrides a same-cycle alloc and issue; any handshake in that cycle is void.
- tagw is carried unchanged; it is never cleared by broadcasts.

Optional Feature:
- Macro: RS_LS_QUEUE_BYPASS_EN.
- Defined:
  - iss_valid also asserts when each head tag is either UNLOCKED or matches a valid broadcast this cycle.
  - iss_datax/iss_datay select the broadcast data combinationally.
  - Issue occurs in the same cycle as the last operand broadcast.
- Undefined: issue only from registered state, as specified above (one-cycle-later issue).

Decomposition:
- Shared package/defines hold:
  - UNLOCKED tag constant.
  - tag, word, op and regaddr type widths.
  - A function for broadcast tag match with lowest-index priority.
- One natural sub-module, rs_ls_entry_cap: a single operand's tag/data register with NUM_BCAST capture logic. It is instantiated twice per entry (x and y) and also used to filter the allocation-time inputs.

Test Plan:
- Reset check:
  - Stimulus: hold rst=0 mid-traffic with 3 entries held, then release.
  - Required: count=0, full=0, iss_valid=0; next alloc lands at slot 0.
- Fill and drain:
  - Stimulus: 4 allocs with tags UNLOCKED, data 0x10..0x13, iss_ready=0, then a 5th alloc.
  - Required: full=1; the 5th is dropped.
  - Then raise iss_ready: issues datax 0x10,0x11,0x12,0x13 in order, one per cycle; count reaches 0.
- Head blocking:
  - Stimulus: head waits on tagx=5; entry 2 is fully ready.
  - Required: iss_valid=0.
  - Stimulus: bc_valid[1]=1, tag 5, data 0xDEAD.
  - Required: next cycle iss_valid=1, iss_datax=0xDEAD; entry 2 follows.
- Alloc-time capture and priority:
  - Stimulus: alloc tagy=7 while channel 0 broadcasts (7, 0xAAAA) and channel 2 broadcasts (7, 0xBBBB).
  - Required: entry stores 0xAAAA, UNLOCKED.
- Stall, backpressure and wrap-around:
  - Stimulus: toggle rdy low and iss_ready low for 3 cycles each while issuing.
  - Required: iss_* stable; no pop or duplicate; 10 consecutive alloc/issue pairs across a DEPTH=4 wrap preserve order.
- Flush and bypass:
  - Stimulus: flush with 2 entries held and alloc_en=1.
  - Required: count=0 next cycle.
  - With RS_LS_QUEUE_BYPASS_EN defined, broadcast of the head's last tag gives iss_valid in the same cycle.
